// File: rtl/spi_pkg.sv
// Shared constants for the SPI accelerometer front end.
//   CLK_HZ            system clock frequency
//   SCLK_HALF_DEF     clk cycles per sclk half-period (5 MHz sclk)
//   DISP_HALF_DEF     clk cycles per disp_clk half-period (1 kHz disp_clk)
//   BITS_PER_BYTE_DEF sclk rising edges per counted byte
//   cnt_width()       width of a counter that must hold 0..n-1 (minimum 1 bit)
package spi_pkg;

  localparam int unsigned CLK_HZ            = 100_000_000;
  localparam int unsigned SCLK_HALF_DEF     = 10;
  localparam int unsigned DISP_HALF_DEF     = 50_000;
  localparam int unsigned BITS_PER_BYTE_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_timebase_div.sv
// Half-period toggle divider with registered edge strobes.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   clk_o   divided clock, 50% duty, period 2*HALF clk cycles
//   rise_o  one-clk pulse in the first cycle clk_o reads 1
//   fall_o  one-clk pulse in the first cycle clk_o reads 0
module spi_timebase_div
  import spi_pkg::*;
#(
  parameter int unsigned HALF = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    W    = cnt_width(HALF);
  localparam logic [W-1:0]   TERM = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;
  logic         terminal;

  // Strobes are computed from the pre-toggle level so they land in the same
  // register update as the toggle itself.
  always_comb begin
    terminal = (cnt_q == TERM);
    cnt_d    = terminal ? '0 : cnt_q + 1'b1;
    clk_d    = clk_q ^ terminal;
    rise_d   = terminal & ~clk_q;
    fall_d   = terminal & clk_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_timebase.sv
// Timebase for the SPI accelerometer front end: sclk generator, display-mux
// clock generator and the transfer bit/byte counter.
//   clk         100 MHz system clock
//   rst_n       asynchronous active-low reset
//   cnt_clr     synchronous clear of bit and byte counters (highest priority)
//   cnt_en      count sclk rising strobes
//   sclk        serial clock (registered), sclk_rise/sclk_fall edge strobes
//   disp_clk    display-mux clock (registered), disp_tick rising strobe
//   byte_count  completed bytes since clear, modulo 4
//   byte_done   one-clk pulse coincident with each byte_count increment
// Generated clocks are data signals; downstream logic uses the strobes as
// clock enables.
module spi_timebase
  import spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF     = SCLK_HALF_DEF,
  parameter int unsigned DISP_HALF     = DISP_HALF_DEF,
  parameter int unsigned BITS_PER_BYTE = BITS_PER_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_clr,
  input  logic       cnt_en,
  output logic       sclk,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       disp_clk,
  output logic       disp_tick,
  output logic [1:0] byte_count,
  output logic       byte_done
);

  localparam int unsigned   BW       = cnt_width(BITS_PER_BYTE);
  localparam logic [BW-1:0] BIT_TERM = BW'(BITS_PER_BYTE - 1);

  logic disp_fall_unused;

  spi_timebase_div #(.HALF(SCLK_HALF)) u_sclk_div (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clk_o  (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_timebase_div #(.HALF(DISP_HALF)) u_disp_div (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clk_o  (disp_clk),
    .rise_o (disp_tick),
    .fall_o (disp_fall_unused)
  );

  logic [BW-1:0] bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic          done_q, done_d;

  // Clear beats a coincident rise; a disabled rise leaves partial progress.
  always_comb begin
    bit_d  = bit_q;
    byte_d = byte_q;
    done_d = 1'b0;
    if (cnt_clr) begin
      bit_d  = '0;
      byte_d = '0;
    end else if (cnt_en && sclk_rise) begin
      if (bit_q == BIT_TERM) begin
        bit_d  = '0;
        byte_d = byte_q + 2'd1;
        done_d = 1'b1;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q  <= '0;
      byte_q <= '0;
      done_q <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      byte_q <= byte_d;
      done_q <= done_d;
    end
  end

  assign byte_count = byte_q;
  assign byte_done  = done_q;

endmodule

// File: tb/tb_spi_timebase.sv
module tb_spi_timebase;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cnt_clr;
  logic       cnt_en;
  logic       sclk, sclk_rise, sclk_fall;
  logic       disp_clk, disp_tick;
  logic [1:0] byte_count;
  logic       byte_done;

  spi_timebase #(.SCLK_HALF(10), .DISP_HALF(5), .BITS_PER_BYTE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr    (cnt_clr),
    .cnt_en     (cnt_en),
    .sclk       (sclk),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .disp_clk   (disp_clk),
    .disp_tick  (disp_tick),
    .byte_count (byte_count),
    .byte_done  (byte_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k        = 0;   // clk edges since reset release
  int         rise_seen;
  int         first_rise;
  int         m_bits;
  logic [1:0] m_bytes;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: advance, sample #1 after the edge, update reference, compare.
  task automatic step();
    logic       r, e, c, pushed;
    logic [1:0] exp_b;
    r = sclk_rise; e = cnt_en; c = cnt_clr; pushed = 1'b0;
    @(posedge clk); #1;
    k++;
    if (c) begin
      m_bits  = 0;
      m_bytes = 2'd0;
    end else if (e && r) begin
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        m_bytes++;
        exp_q.push_back(m_bytes);
        pushed = 1'b1;
      end
    end
    chk("sclk",      sclk,      ((k / 10) % 2) == 1);
    chk("sclk_rise", sclk_rise, (k % 20) == 10);
    chk("sclk_fall", sclk_fall, (k > 0) && ((k % 20) == 0));
    chk("disp_clk",  disp_clk,  ((k / 5) % 2) == 1);
    chk("disp_tick", disp_tick, (k % 10) == 5);
    chk("byte_done", byte_done, pushed);
    if (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      chk("sb_byte_count", byte_count, exp_b);
    end
    chk("byte_count", byte_count, m_bytes);
    if (sclk_rise === 1'b1) begin
      rise_seen++;
      if (first_rise < 0) first_rise = k;
    end
  endtask

  // Run until n rise strobes are seen, then one more cycle so the last rise
  // has been consumed by the counter.
  task automatic run_rises(input int n);
    int got   = 0;
    int guard = 0;
    while (got < n && guard < n * 20 + 40) begin
      step();
      guard++;
      if (sclk_rise === 1'b1) got++;
    end
    chk("run_rises_bound", got, n);
    step();
  endtask

  // Run until the current sample shows a rise strobe.
  task automatic wait_rise();
    int guard = 0;
    while (sclk_rise !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    chk("wait_rise_bound", sclk_rise, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    m_bits  = 0;
    m_bytes = 2'd0;
    #22;
    chk("rst_sclk",       sclk,       1'b0);
    chk("rst_sclk_rise",  sclk_rise,  1'b0);
    chk("rst_sclk_fall",  sclk_fall,  1'b0);
    chk("rst_disp_clk",   disp_clk,   1'b0);
    chk("rst_disp_tick",  disp_tick,  1'b0);
    chk("rst_byte_count", byte_count, 2'd0);
    chk("rst_byte_done",  byte_done,  1'b0);

    // free run: sclk and disp_clk waveform checked every cycle inside step
    rst_n      = 1'b1;
    k          = 0;
    rise_seen  = 0;
    first_rise = -1;
    repeat (200) step();
    chk("first_rise_cycle", first_rise, 10);
    chk("rise_count_200",   rise_seen,  10);

    // four full bytes: 1, 2, 3 then wrap to 0
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    cnt_en = 1'b1;
    run_rises(8);  chk("bytes_after_8",  byte_count, 2'd1);
    run_rises(8);  chk("bytes_after_16", byte_count, 2'd2);
    run_rises(8);  chk("bytes_after_24", byte_count, 2'd3);
    run_rises(8);  chk("bytes_after_32", byte_count, 2'd0);

    // enable gap holds partial bit progress
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    run_rises(5);
    cnt_en = 1'b0;
    run_rises(10); chk("gap_hold",        byte_count, 2'd0);
    cnt_en = 1'b1;
    run_rises(2);  chk("resume_2",        byte_count, 2'd0);
    run_rises(1);  chk("resume_3",        byte_count, 2'd1);

    // clear coincident with the rise that would complete byte 3
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    run_rises(23); chk("pre_clr_bytes",   byte_count, 2'd2);
    wait_rise();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_wins_count", byte_count, 2'd0);
    chk("clr_wins_done",  byte_done,  1'b0);

    // asynchronous reset while sclk is high, between clk edges
    run_rises(8);  chk("pre_rst_bytes",   byte_count, 2'd1);
    wait_rise();
    step();
    step();
    chk("pre_rst_sclk_high", sclk, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sclk",  sclk,       1'b0);
    chk("async_rst_bytes", byte_count, 2'd0);
    chk("async_rst_rise",  sclk_rise,  1'b0);
    #2;
    rst_n      = 1'b1;
    k          = 0;
    m_bits     = 0;
    m_bytes    = 2'd0;
    exp_q.delete();
    first_rise = -1;
    repeat (12) step();
    chk("post_rst_first_rise", first_rise, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
